// File: rtl/alu_apb_arbiter.sv
// -----------------------------------------------------------------------------
// alu_apb_arbiter
//
// Two-port APB master sharing the single APB slave port of the ALU register
// block between two requesters. Each requester raises reqN with addrN,
// writeN and wdataN, and holds reqN until doneN pulses. The block arbitrates
// round-robin, drives the APB SETUP/ACCESS sequence and waits on pready. A
// bounded wait counter aborts a hung ACCESS phase and reports err.
//
// Parameters:
//   TIMEOUT  ACCESS-phase cycles without pready before abort (2..255)
//   ADDR_W   APB address width
//   DATA_W   APB data width
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   req0/addr0/write0/wdata0   port 0 request, address, direction, data
//   done0                      port 0 one-cycle completion pulse
//   req1/addr1/write1/wdata1   port 1 request, address, direction, data
//   done1                      port 1 one-cycle completion pulse
//   rdata, err                 read data / timeout flag, valid with a done
//   psel, penable, paddr,
//   pwrite, pwdata             APB master outputs
//   prdata, pready             APB slave responses
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module alu_apb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // Requester port 0
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              write0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  // Requester port 1
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              write1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  // Shared completion status
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  // APB master
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter value on the last permitted ACCESS cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;       // port that owns the transfer in flight
  logic       last_grant;  // port served most recently
  logic [7:0] wait_cnt;    // ACCESS cycles elapsed without pready

  logic req0_eff;
  logic req1_eff;
  logic pick1;

  // A port's own done cycle masks its request, so the transfer that just
  // completed is never issued a second time while the requester is still
  // lowering req.
  assign req0_eff = req0 & ~done0;
  assign req1_eff = req1 & ~done1;

  // Port 1 wins when it requests alone, or when both request and port 1 was
  // not the last one served.
  assign pick1 = req1_eff & (~req0_eff | ~last_grant);

  // NOTE: every register here lives in one clocked block with non-blocking
  // assignments and an asynchronous reset branch, so the bus drops
  // immediately on reset_n even in the middle of a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the completing ACCESS cycle
      // raises it again.
      done0 <= 1'b0;
      done1 <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_eff || req1_eff) begin
            owner   <= pick1;
            paddr   <= pick1 ? addr1  : addr0;
            pwrite  <= pick1 ? write1 : write0;
            pwdata  <= pick1 ? wdata1 : wdata0;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (pready || (wait_cnt == WAIT_LAST)) begin
            // Completion and timeout share one exit path; only rdata and
            // err distinguish them.
            rdata      <= (pready && !pwrite) ? prdata : '0;
            err        <= ~pready;
            done0      <= ~owner;
            done1      <= owner;
            last_grant <= owner;
            psel       <= 1'b0;
            penable    <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
